// File: rtl/icache_pkg.sv
// icache_pkg: shared geometry, FSM states, tag entry layout and address slicing for the icache tag path
package icache_pkg;
  localparam int ADDR_W   = 32;
  localparam int INDEX_W  = 8;
  localparam int OFFSET_W = 5;
  localparam int TAG_W    = 19;
  typedef enum logic [2:0] {
    FLUSH  = 3'd0,
    IDLE   = 3'd1,
    LOOKUP = 3'd2,
    MISS   = 3'd3,
    FILL   = 3'd4
  } state_e;
  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
  } tag_entry_t;
  function automatic logic [TAG_W-1:0] addr_tag(input logic [ADDR_W-1:0] a);
    return a[ADDR_W-1 -: TAG_W];
  endfunction
  function automatic logic [INDEX_W-1:0] addr_index(input logic [ADDR_W-1:0] a);
    return a[OFFSET_W +: INDEX_W];
  endfunction
  function automatic logic [ADDR_W-1:0] line_base(input logic [ADDR_W-1:0] a);
    return {a[ADDR_W-1:OFFSET_W], OFFSET_W'(0)};
  endfunction
endpackage

// File: rtl/icache_tag_ram.sv
// icache_tag_ram: 256x20 single-port tag store, registered read, read-before-write
module icache_tag_ram
  import icache_pkg::*;
(
  input  logic               clk_i,
  input  logic [INDEX_W-1:0] addr,
  input  logic               we,
  input  tag_entry_t         wdata,
  output tag_entry_t         rdata
);
  tag_entry_t mem [2**INDEX_W];
  always_ff @(posedge clk_i) begin
    rdata <= mem[addr];
    if (we) mem[addr] <= wdata;
  end
endmodule

// File: rtl/icache_tag_ctrl.sv
// icache_tag_ctrl: icache tag lookup/refill/flush controller owning the tag RAM port.
// Optional hit/miss counters enabled by ICACHE_TAG_STATS_EN.
module icache_tag_ctrl
  import icache_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [ADDR_W-1:0] req_addr_i,
  output logic              resp_valid_o,
  output logic              resp_refilled_o,
  output logic [ADDR_W-1:0] resp_addr_o,
  output logic              refill_req_o,
  output logic [ADDR_W-1:0] refill_addr_o,
  input  logic              refill_done_i,
  input  logic              flush_i,
`ifdef ICACHE_TAG_STATS_EN
  output logic [31:0]       hit_cnt_o,
  output logic [31:0]       miss_cnt_o,
`endif
  output logic              busy_o
);
  state_e             state_q;
  logic [INDEX_W-1:0] cnt_q;
  logic               flush_pend_q;
  logic [ADDR_W-1:0]  req_q;
  logic [INDEX_W-1:0] ram_addr;
  logic               ram_we;
  tag_entry_t         ram_wdata;
  tag_entry_t         ram_rdata;
  logic               flush_any;
  logic               hit;
  logic               accept;
  assign flush_any = flush_pend_q | flush_i;
  assign hit       = state_q == LOOKUP && ram_rdata.valid && ram_rdata.tag == addr_tag(req_q);
  // a pending flush blocks new requests so it runs before the next lookup
  assign req_ready_o     = !flush_any && (state_q == IDLE || hit);
  assign accept          = req_valid_i && req_ready_o;
  assign resp_valid_o    = hit || state_q == FILL;
  assign resp_refilled_o = state_q == FILL;
  assign resp_addr_o     = req_q;
  assign refill_req_o    = state_q == MISS;
  assign refill_addr_o   = line_base(req_q);
  assign busy_o          = state_q == FLUSH || state_q == MISS || state_q == FILL;
  // sweep and fill write; otherwise the port reads the incoming request's set
  assign ram_addr  = state_q == FLUSH ? cnt_q : state_q == FILL ? addr_index(req_q) : addr_index(req_addr_i);
  assign ram_we    = state_q == FLUSH || state_q == FILL;
  assign ram_wdata = state_q == FILL ? tag_entry_t'{valid: 1'b1, tag: addr_tag(req_q)} : '0;
  icache_tag_ram u_ram (
    .clk_i (clk_i),
    .addr  (ram_addr),
    .we    (ram_we),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= FLUSH;
      cnt_q        <= '0;
      flush_pend_q <= 1'b0;
      req_q        <= '0;
    end else begin
      if (accept) req_q <= req_addr_i;
      case (state_q)
        FLUSH: begin
          cnt_q        <= cnt_q + INDEX_W'(1);
          flush_pend_q <= 1'b0;
          if (&cnt_q) state_q <= IDLE;
        end
        IDLE: begin
          if (flush_any) begin
            state_q      <= FLUSH;
            cnt_q        <= '0;
            flush_pend_q <= 1'b0;
          end else if (req_valid_i) state_q <= LOOKUP;
        end
        LOOKUP: begin
          flush_pend_q <= flush_any;
          state_q      <= !hit ? MISS : accept ? LOOKUP : IDLE;
        end
        MISS: begin
          flush_pend_q <= flush_any;
          if (refill_done_i) state_q <= FILL;
        end
        FILL: begin
          flush_pend_q <= flush_any;
          state_q      <= IDLE;
        end
        default: state_q <= FLUSH;
      endcase
    end
  end
`ifdef ICACHE_TAG_STATS_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hit_cnt_o  <= '0;
      miss_cnt_o <= '0;
    end else begin
      if (hit && !(&hit_cnt_o)) hit_cnt_o <= hit_cnt_o + 32'd1;
      if (state_q == LOOKUP && !hit && !(&miss_cnt_o)) miss_cnt_o <= miss_cnt_o + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_icache_tag_ctrl.sv
// tb_icache_tag_ctrl: directed scoreboard bench for icache_tag_ctrl (default build)
module tb_icache_tag_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = '0;
  logic        resp_valid;
  logic        resp_refilled;
  logic [31:0] resp_addr;
  logic        refill_req;
  logic [31:0] refill_addr;
  logic        refill_done = 1'b0;
  logic        flush = 1'b0;
  logic        busy;
  int          compared = 0;
  int          mismatched = 0;
  logic [32:0] sb [$];
  logic [32:0] exp_resp;
  logic [32:0] dropped;
  always #5 clk = ~clk;
  icache_tag_ctrl dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .req_valid_i     (req_valid),
    .req_ready_o     (req_ready),
    .req_addr_i      (req_addr),
    .resp_valid_o    (resp_valid),
    .resp_refilled_o (resp_refilled),
    .resp_addr_o     (resp_addr),
    .refill_req_o    (refill_req),
    .refill_addr_o   (refill_addr),
    .refill_done_i   (refill_done),
    .flush_i         (flush),
    .busy_o          (busy)
  );
  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask
  always @(negedge clk) begin
    if (rst_n && resp_valid) begin
      exp_resp = sb.size() != 0 ? sb.pop_front() : 33'h1_DEAD_BEEF;
      check("resp {refilled,addr}", {resp_refilled, resp_addr}, exp_resp);
    end
  end
  task automatic wait_ready(input int exp, input string nm);
    int n = 0;
    while (!req_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check(nm, n, exp);
  endtask
  task automatic accept(input logic [31:0] a);
    int t = 0;
    req_valid = 1'b1;
    req_addr  = a;
    while (!req_ready && t < 1000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 1000) check("accept timeout", 0, 1);
    @(negedge clk);
    req_valid = 1'b0;
  endtask
  task automatic hit(input logic [31:0] a);
    sb.push_back({1'b0, a});
    accept(a);
    check("hit latency {valid,refilled}", {resp_valid, resp_refilled}, 2'b10);
  endtask
  task automatic wait_miss();
    int n = 0;
    while (!refill_req && n < 50) begin
      @(negedge clk);
      n++;
    end
  endtask
  task automatic do_miss(input logic [31:0] a, input bit fl);
    sb.push_back({1'b1, a});
    accept(a);
    check("miss no resp", resp_valid, 0);
    wait_miss();
    check("refill_req", refill_req, 1);
    check("refill_addr", refill_addr, a & 32'hFFFF_FFE0);
    if (fl) begin
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      check("refill_req held after flush", refill_req, 1);
    end
    @(negedge clk);
    refill_done = 1'b1;
    @(negedge clk);
    refill_done = 1'b0;
    check("fill resp {valid,refilled}", {resp_valid, resp_refilled}, 2'b11);
  endtask
  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    repeat (2) @(negedge clk);
    check("reset req_ready", req_ready, 0);
    check("reset resp_valid", resp_valid, 0);
    check("reset refill_req", refill_req, 0);
    check("reset refill_addr", refill_addr, 0);
    rst_n = 1'b1;
    wait_ready(256, "initial sweep length");
    do_miss(32'h0000_1234, 1'b0);
    hit(32'h0000_1238);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) check("burst req_ready held", req_ready, 1);
      hit(32'h0000_1220 + 32'(i * 4));
    end
    do_miss(32'h0010_1220, 1'b0);
    do_miss(32'h0000_1220, 1'b0);
    hit(32'h0000_1224);
    @(negedge clk);
    do_miss(32'h0000_2040, 1'b1);
    wait_ready(258, "flush after fill length");
    do_miss(32'h0000_2044, 1'b0);
    sb.push_back({1'b1, 32'h0000_3000});
    accept(32'h0000_3000);
    wait_miss();
    check("miss before reset", refill_req, 1);
    rst_n = 1'b0;
    #1;
    check("async reset refill_req", refill_req, 0);
    check("async reset req_ready", req_ready, 0);
    dropped = sb.pop_back();
    @(negedge clk);
    refill_done = 1'b1;
    @(negedge clk);
    refill_done = 1'b0;
    rst_n = 1'b1;
    wait_ready(256, "sweep after reset");
    do_miss(32'h0000_3000, 1'b0);
    repeat (5) @(negedge clk);
    check("scoreboard drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
